// File: rtl/fm_tile_loader.sv
// Packs an 8-bit pixel stream into 64-bit input_fm tiles and holds them in a
// 2-entry ping-pong buffer that feeds computation_engine over valid/ready.
module fm_tile_loader #(
  parameter int PIX_W  = 8,
  parameter int TILE_N = 8,
  parameter int TILE_W = PIX_W * TILE_N,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [TILE_W-1:0] m_tile,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  tile_cnt,
  output logic [1:0]        dbg_occ
);

  localparam int PC_W = (TILE_N > 1) ? $clog2(TILE_N) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [PC_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]  tile_cnt_q, tile_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic [TILE_W-1:0] tile_buf_q [2];
  logic [1:0]        last_q;

  logic accept, pop, commit;

  // Both ports use valid/ready: a beat transfers on the rising edge where
  // valid and ready are both high; data is held stable while valid waits.
  assign accept = s_valid & s_ready_q;
  assign pop    = m_valid & m_ready;
  assign commit = accept & (s_last | (pix_cnt_q == PC_W'(TILE_N - 1)));

  always_comb begin
    occ_d      = occ_q;
    pix_cnt_d  = pix_cnt_q;
    wr_sel_d   = wr_sel_q ^ commit;
    rd_sel_d   = rd_sel_q ^ pop;
    tile_cnt_d = tile_cnt_q + CNT_W'(pop);
    case (occ_q)
      EMPTY:   if (commit) occ_d = ONE;
      ONE: begin
        if (commit && !pop)      occ_d = FULL;
        else if (!commit && pop) occ_d = EMPTY;
      end
      FULL:    if (pop) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
    if (accept) pix_cnt_d = commit ? '0 : pix_cnt_q + PC_W'(1);
    // Ready is registered from the next occupancy so it drops only in FULL.
    s_ready_d = (occ_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= EMPTY;
      pix_cnt_q  <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      tile_cnt_q <= '0;
      s_ready_q  <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      pix_cnt_q  <= pix_cnt_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      tile_cnt_q <= tile_cnt_d;
      s_ready_q  <= s_ready_d;
    end
  end

  // The first pixel of a tile clears the stale bytes so short frames pad with 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_buf_q[0] <= '0;
      tile_buf_q[1] <= '0;
      last_q        <= '0;
    end else if (accept) begin
      if (pix_cnt_q == '0)
        tile_buf_q[wr_sel_q] <= {{(TILE_W - PIX_W){1'b0}}, s_data};
      else
        tile_buf_q[wr_sel_q][int'(pix_cnt_q) * PIX_W +: PIX_W] <= s_data;
      if (commit) last_q[wr_sel_q] <= s_last;
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = (occ_q != EMPTY);
  assign m_tile   = tile_buf_q[rd_sel_q];
  assign m_last   = last_q[rd_sel_q];
  assign tile_cnt = tile_cnt_q;
  assign dbg_occ  = occ_q;

endmodule

// File: tb/tb_fm_tile_loader.sv
// Bench for fm_tile_loader: directed scenarios plus random traffic checked
// against a queue-level model of pixels, tiles and pops.
module tb_fm_tile_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [63:0] m_tile;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [15:0] tile_cnt;
  logic [1:0]  dbg_occ;

  fm_tile_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_tile   (m_tile),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .tile_cnt (tile_cnt),
    .dbg_occ  (dbg_occ)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [63:0] exp_q[$];
  logic        exp_last_q[$];
  logic [7:0]  part_q[$];
  logic [15:0] exp_cnt;
  int          pops;
  bit          rdy_ok;
  bit          chk_en;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("s_ready", 64'(s_ready), 64'(rdy_ok && exp_q.size() < 2));
    chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
    chk("occ", 64'(dbg_occ), 64'(exp_q.size()));
    chk("tile_cnt", 64'(tile_cnt), 64'(exp_cnt));
    if (exp_q.size() != 0) begin
      chk("m_tile", m_tile, exp_q[0]);
      chk("m_last", 64'(m_last), 64'(exp_last_q[0]));
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    part_q.delete();
    exp_cnt = '0;
    pops    = 0;
    rdy_ok  = 1'b0;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_tile", m_tile, 64'd0);
    chk("rst_tile_cnt", 64'(tile_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; the model advances by the transfer rules.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit mr,
                      output bit acc);
    bit pop;
    logic [63:0] t;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    acc = v && rdy_ok && (exp_q.size() < 2);
    pop = mr && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(exp_last_q.pop_front());
      exp_cnt++;
      pops++;
    end
    if (acc) begin
      part_q.push_back(d);
      if (part_q.size() == 8 || l) begin
        t = '0;
        for (int k = 0; k < part_q.size(); k++) t[8*k +: 8] = part_q[k];
        exp_q.push_back(t);
        exp_last_q.push_back(l);
        part_q.delete();
      end
    end
    rdy_ok = 1'b1;
    if (chk_en) check_outputs();
  endtask

  task automatic send_pix(input logic [7:0] d, input bit l, input bit mr);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1'b1, d, l, mr, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input bit mr);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom), mr, acc);
  endtask

  initial begin
    bit acc;
    n_cmp  = 0;
    n_err  = 0;
    chk_en = 1'b1;
    do_reset();
    idle(1, 1'b0);

    // 1: full tile
    for (int i = 1; i <= 8; i++) send_pix(8'(i), 1'b0, 1'b0);
    chk("t1_tile", m_tile, 64'h0807060504030201);
    chk("t1_last", 64'(m_last), 64'd0);
    idle(1, 1'b1);
    chk("t1_cnt", 64'(tile_cnt), 64'd1);

    // 2: short frame, then a tile that must not see stale bytes
    send_pix(8'hAA, 1'b0, 1'b0);
    send_pix(8'hBB, 1'b0, 1'b0);
    send_pix(8'hCC, 1'b1, 1'b0);
    chk("t2_tile", m_tile, 64'h0000000000CCBBAA);
    chk("t2_last", 64'(m_last), 64'd1);
    idle(1, 1'b1);
    send_pix(8'h5A, 1'b1, 1'b1);
    chk("t2_nostale", m_tile, 64'h000000000000005A);
    idle(2, 1'b1);

    // 3: backpressure fills both entries, 17th pixel held
    for (int i = 1; i <= 16; i++) send_pix(8'(i), 1'b0, 1'b0);
    chk("t3_full_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd17, 1'b0, 1'b0, acc);
    chk("t3_tile_a", m_tile, 64'h0807060504030201);
    send_pix(8'd17, 1'b0, 1'b1);
    idle(3, 1'b1);

    // 4: commit and pop in the same cycle while ONE
    do_reset();
    idle(1, 1'b0);
    for (int i = 0; i < 8; i++) send_pix(8'h20 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_pix(8'h30 + 8'(i), 1'b0, 1'b0);
    send_pix(8'h37, 1'b0, 1'b1);
    chk("t4_occ", 64'(dbg_occ), 64'd1);
    chk("t4_tile", m_tile, 64'h3736353433323130);
    idle(2, 1'b1);

    // 5: mid-operation reset with buffered and partial data
    for (int i = 0; i < 13; i++) send_pix(8'($urandom), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_m_valid", 64'(m_valid), 64'd0);
    chk("t5_s_ready", 64'(s_ready), 64'd0);
    chk("t5_m_tile", m_tile, 64'd0);
    chk("t5_tile_cnt", 64'(tile_cnt), 64'd0);
    do_reset();
    idle(1, 1'b0);
    for (int i = 0; i < 8; i++) send_pix(8'h11 + 8'(i), 1'b0, 1'b0);
    chk("t5_tile", m_tile, 64'h1817161514131211);
    idle(2, 1'b1);

    // random traffic with junk on idle inputs
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) != 0), acc);
    idle(4, 1'b1);

    // 6: counter wrap, one-pixel tiles for one pop per cycle
    do_reset();
    chk_en = 1'b0;
    for (int i = 0; i < 70000 && pops < 65535; i++)
      step(1'b1, 8'($urandom), 1'b1, 1'b1, acc);
    chk("t6_pre", 64'(tile_cnt), 64'hFFFF);
    step(1'b0, 8'd0, 1'b0, 1'b1, acc);
    chk("t6_pops", 64'(pops), 64'd65536);
    chk("t6_wrap", 64'(tile_cnt), 64'h0000);
    chk_en = 1'b1;
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
